lsu_dcache_arb: RTL and testbench

- Owns the single data-cache port of the load/store unit and schedules three requesters onto it:
  - store-drain (committed stores from the SAQ/SDQ),
  - load-replay (loads re-issued from the LAQ after a miss),
  - new loads from the AGU.
- Issues one access at a time and tracks the in-flight access through a fixed-latency response.
- Routes load hits to register writeback and misses back to replay.
- Suppresses in-flight loads killed by branch misprediction.

---
 rtl/lsu_dcache_arb.sv | 142 ++++++++++++++
 tb/tb_lsu_dcache_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dcache_arb.sv
// Data-cache port arbiter for the load/store unit: schedules store-drain, load-replay
// and AGU loads onto one port, tracks the in-flight access and routes its response.
module lsu_dcache_arb #(
   parameter int WIDTH_MEM  = 4,
   parameter int WIDTH_REG  = 5,
   parameter int WIDTH_BRM  = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_st_req,
   input  logic [WIDTH_MEM-1:0]    i_st_addr,
   input  logic [31:0]             i_st_data,
   output logic                    o_st_gnt,
   input  logic                    i_lr_req,
   input  logic [WIDTH_MEM-1:0]    i_lr_addr,
   input  logic [WIDTH_REG-1:0]    i_lr_rd,
   input  logic [2**WIDTH_BRM-1:0] i_lr_brmask,
   output logic                    o_lr_gnt,
   input  logic                    i_ag_req,
   input  logic [WIDTH_MEM-1:0]    i_ag_addr,
   input  logic [WIDTH_REG-1:0]    i_ag_rd,
   input  logic [2**WIDTH_BRM-1:0] i_ag_brmask,
   output logic                    o_ag_gnt,
   input  logic [2**WIDTH_BRM-1:0] i_brkill,
   output logic                    o_dc_req,
   output logic                    o_dc_we,
   output logic [WIDTH_MEM-1:0]    o_dc_addr,
   output logic [31:0]             o_dc_data,
   input  logic                    i_dc_ready,
   input  logic                    i_dc_hit,
   output logic                    o_wb_valid,
   output logic [WIDTH_REG-1:0]    o_wb_rd,
   output logic                    o_replay,
   output logic [WIDTH_REG-1:0]    o_replay_rd
);

   localparam int BMW = 2**WIDTH_BRM;
   localparam int CW  = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, RESP, BLOCK} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        starve_reg, starve_next;
   logic                 fl_valid_reg, fl_valid_next;
   logic                 fl_load_reg, fl_load_next;
   logic [WIDTH_REG-1:0] fl_rd_reg, fl_rd_next;
   logic [BMW-1:0]       fl_mask_reg, fl_mask_next;

   logic resp, killed, live, miss, can_grant, starved, any_gnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         starve_reg   <= '0;
         fl_valid_reg <= 1'b0;
         fl_load_reg  <= 1'b0;
         fl_rd_reg    <= '0;
         fl_mask_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         starve_reg   <= starve_next;
         fl_valid_reg <= fl_valid_next;
         fl_load_reg  <= fl_load_next;
         fl_rd_reg    <= fl_rd_next;
         fl_mask_reg  <= fl_mask_next;
      end
   end

   always_comb begin
      resp      = (state_reg == RESP);
      // A kill arriving in the response cycle itself still suppresses the load.
      killed    = fl_load_reg && (|(fl_mask_reg & i_brkill));
      live      = resp && fl_valid_reg && !killed;
      miss      = live && !i_dc_hit;
      starved   = i_st_req && (starve_reg >= CW'(STARVE_MAX));
      can_grant = !i_rst && !miss && (state_reg != BLOCK) && i_dc_ready;

      o_lr_gnt  = can_grant && i_lr_req && !starved;
      o_ag_gnt  = can_grant && i_ag_req && !i_lr_req && !starved;
      o_st_gnt  = can_grant && i_st_req && (starved || (!i_lr_req && !i_ag_req));
      any_gnt   = o_lr_gnt || o_ag_gnt || o_st_gnt;

      o_dc_req  = any_gnt;
      o_dc_we   = o_st_gnt;
      o_dc_addr = '0;
      o_dc_data = '0;
      if (o_lr_gnt) begin
         o_dc_addr = i_lr_addr;
      end else if (o_ag_gnt) begin
         o_dc_addr = i_ag_addr;
      end else if (o_st_gnt) begin
         o_dc_addr = i_st_addr;
         o_dc_data = i_st_data;
      end

      o_wb_valid  = live && fl_load_reg && i_dc_hit;
      o_wb_rd     = o_wb_valid ? fl_rd_reg : '0;
      o_replay    = miss && fl_load_reg;
      o_replay_rd = o_replay ? fl_rd_reg : '0;

      starve_next = starve_reg;
      if (!i_st_req || o_st_gnt) begin
         starve_next = '0;
      end else if (starve_reg < CW'(STARVE_MAX)) begin
         starve_next = starve_reg + CW'(1);
      end

      fl_valid_next = 1'b0;
      fl_load_next  = fl_load_reg;
      fl_rd_next    = fl_rd_reg;
      fl_mask_next  = fl_mask_reg;
      if (o_lr_gnt) begin
         fl_load_next  = 1'b1;
         fl_rd_next    = i_lr_rd;
         fl_mask_next  = i_lr_brmask;
         fl_valid_next = ~|(i_lr_brmask & i_brkill);
      end else if (o_ag_gnt) begin
         fl_load_next  = 1'b1;
         fl_rd_next    = i_ag_rd;
         fl_mask_next  = i_ag_brmask;
         fl_valid_next = ~|(i_ag_brmask & i_brkill);
      end else if (o_st_gnt) begin
         fl_load_next  = 1'b0;
         fl_rd_next    = '0;
         fl_mask_next  = '0;
         fl_valid_next = 1'b1;
      end

      state_next = state_reg;
      case (state_reg)
         IDLE, RESP: begin
            if (miss)         state_next = BLOCK;
            else if (any_gnt) state_next = RESP;
            else              state_next = IDLE;
         end
         BLOCK:   if (i_dc_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// Bench for lsu_dcache_arb: directed scenarios with literal expectations, then random
// traffic checked each cycle against a transaction-level model of the arbiter.
module tb_lsu_dcache_arb;

   logic        i_clk, i_rst;
   logic        i_st_req, i_lr_req, i_ag_req;
   logic [3:0]  i_st_addr, i_lr_addr, i_ag_addr;
   logic [31:0] i_st_data;
   logic [4:0]  i_lr_rd, i_ag_rd;
   logic [15:0] i_lr_brmask, i_ag_brmask, i_brkill;
   logic        i_dc_ready, i_dc_hit;
   logic        o_st_gnt, o_lr_gnt, o_ag_gnt, o_dc_req, o_dc_we, o_wb_valid, o_replay;
   logic [3:0]  o_dc_addr;
   logic [31:0] o_dc_data;
   logic [4:0]  o_wb_rd, o_replay_rd;

   int tests = 0;
   int fails = 0;

   lsu_dcache_arb dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_st_req(i_st_req), .i_st_addr(i_st_addr), .i_st_data(i_st_data), .o_st_gnt(o_st_gnt),
      .i_lr_req(i_lr_req), .i_lr_addr(i_lr_addr), .i_lr_rd(i_lr_rd),
      .i_lr_brmask(i_lr_brmask), .o_lr_gnt(o_lr_gnt),
      .i_ag_req(i_ag_req), .i_ag_addr(i_ag_addr), .i_ag_rd(i_ag_rd),
      .i_ag_brmask(i_ag_brmask), .o_ag_gnt(o_ag_gnt),
      .i_brkill(i_brkill),
      .o_dc_req(o_dc_req), .o_dc_we(o_dc_we), .o_dc_addr(o_dc_addr), .o_dc_data(o_dc_data),
      .i_dc_ready(i_dc_ready), .i_dc_hit(i_dc_hit),
      .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
      .o_replay(o_replay), .o_replay_rd(o_replay_rd)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an optional pending response record, a blocked flag and a count of
   // consecutive cycles a requesting store has gone without the port.
   logic        m_busy = 1'b0, m_valid = 1'b0, m_load = 1'b0, m_blocked = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [15:0] m_mask = '0;
   int          m_losses = 0;

   always @(negedge i_clk) begin : compare
      int          win;
      logic        kill, e_wb, e_rp, e_miss, open;
      logic [3:0]  e_addr;
      kill   = m_load && (|(m_mask & i_brkill));
      e_wb   = !i_rst && m_busy && m_valid && m_load && !kill && i_dc_hit;
      e_rp   = !i_rst && m_busy && m_valid && m_load && !kill && !i_dc_hit;
      e_miss = e_rp || (!i_rst && m_busy && !m_load && !i_dc_hit);
      open   = !i_rst && !m_blocked && i_dc_ready && !e_miss;
      win    = 0;
      if (open) begin
         if (i_st_req && m_losses >= 8) win = 3;
         else if (i_lr_req)             win = 1;
         else if (i_ag_req)             win = 2;
         else if (i_st_req)             win = 3;
      end
      e_addr = (win == 1) ? i_lr_addr : (win == 2) ? i_ag_addr : i_st_addr;

      chk("lr_gnt", o_lr_gnt, win == 1);
      chk("ag_gnt", o_ag_gnt, win == 2);
      chk("st_gnt", o_st_gnt, win == 3);
      chk("dc_req", o_dc_req, win != 0);
      chk("wb_valid", o_wb_valid, e_wb);
      chk("replay", o_replay, e_rp);
      if (win != 0) begin
         chk("dc_we", o_dc_we, win == 3);
         chk("dc_addr", o_dc_addr, e_addr);
         if (win == 3) chk("dc_data", o_dc_data, i_st_data);
      end
      if (e_wb) chk("wb_rd", o_wb_rd, m_rd);
      if (e_rp) chk("replay_rd", o_replay_rd, m_rd);
      $display("[TB] t=%0t win=%0d wb=%0b rp=%0b blk=%0b", $time, win, e_wb, e_rp, m_blocked);

      if (i_rst) begin
         m_busy = 1'b0; m_valid = 1'b0; m_blocked = 1'b0; m_losses = 0;
      end else begin
         if (e_miss) m_blocked = 1'b1;
         else if (m_blocked && i_dc_ready) m_blocked = 1'b0;
         m_losses = (i_st_req && win != 3) ? m_losses + 1 : 0;
         m_busy   = (win != 0);
         m_load   = (win != 3);
         m_rd     = (win == 1) ? i_lr_rd : i_ag_rd;
         m_mask   = (win == 1) ? i_lr_brmask : (win == 2) ? i_ag_brmask : 16'h0;
         m_valid  = !(m_load && (|(m_mask & i_brkill)));
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
      i_rst = 1'b0; i_st_req = 1'b0; i_lr_req = 1'b0; i_ag_req = 1'b0;
      i_dc_ready = 1'b1; i_dc_hit = 1'b1; i_brkill = '0;
      i_lr_brmask = '0; i_ag_brmask = '0;
   endtask

   initial begin
      int first_st;
      i_rst = 1'b1; i_st_req = 1'b0; i_lr_req = 1'b0; i_ag_req = 1'b0;
      i_st_addr = '0; i_lr_addr = '0; i_ag_addr = '0; i_st_data = '0;
      i_lr_rd = '0; i_ag_rd = '0; i_lr_brmask = '0; i_ag_brmask = '0; i_brkill = '0;
      i_dc_ready = 1'b1; i_dc_hit = 1'b1;

      // Reset holds every output low even with requests pending
      step(); i_rst = 1'b1; i_lr_req = 1'b1; i_ag_req = 1'b1; i_st_req = 1'b1; #2;
      chk("rst_dc_req", o_dc_req, 0);
      chk("rst_gnts", {o_lr_gnt, o_ag_gnt, o_st_gnt}, 0);
      chk("rst_wb", o_wb_valid, 0);

      // Reset arriving while a load response is due
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd4; #2;
      chk("midrst_gnt", o_ag_gnt, 1);
      step(); i_rst = 1'b1; i_lr_req = 1'b1; i_ag_req = 1'b1; i_st_req = 1'b1; #2;
      chk("midrst_wb", o_wb_valid, 0);
      chk("midrst_replay", o_replay, 0);
      step(); i_rst = 1'b1; i_lr_req = 1'b1; i_ag_req = 1'b1; i_st_req = 1'b1; #2;
      chk("midrst_gnts", {o_lr_gnt, o_ag_gnt, o_st_gnt}, 0);
      step();

      // Starvation: the store must win on the ninth contended cycle
      first_st = 0;
      for (int c = 1; c <= 20 && first_st == 0; c++) begin
         step();
         i_lr_req = 1'b1; i_ag_req = 1'b1; i_st_req = 1'b1;
         i_lr_rd = 5'(c); i_lr_addr = 4'(c); i_ag_addr = 4'hE; i_st_addr = 4'h9;
         i_st_data = 32'hCAFE0000 | c;
         #2;
         if (c == 1) chk("starve_first_lr", o_lr_gnt, 1);
         if (o_st_gnt) begin
            first_st = c;
            chk("starve_we", o_dc_we, 1);
            chk("starve_data", o_dc_data, 32'hCAFE0000 | c);
         end
      end
      chk("starve_cycle", first_st, 9);
      step();

      // AGU hit: writeback exactly one cycle after the grant
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd5; i_ag_addr = 4'h3; #2;
      chk("hit_gnt", o_ag_gnt, 1);
      chk("hit_addr", o_dc_addr, 4'h3);
      chk("hit_we", o_dc_we, 0);
      step(); #2;
      chk("hit_wb", o_wb_valid, 1);
      chk("hit_wb_rd", o_wb_rd, 5);

      // AGU miss: replay, block while not ready, first grant one cycle after ready
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd7; i_ag_addr = 4'h1; #2;
      chk("miss_gnt", o_ag_gnt, 1);
      step(); i_dc_hit = 1'b0; i_ag_req = 1'b1; i_ag_rd = 5'd9; #2;
      chk("miss_replay", o_replay, 1);
      chk("miss_replay_rd", o_replay_rd, 7);
      chk("miss_no_gnt", o_ag_gnt, 0);
      for (int k = 0; k < 3; k++) begin
         step(); i_dc_ready = 1'b0; i_ag_req = 1'b1; #2;
         chk("block_no_req", o_dc_req, 0);
      end
      step(); i_ag_req = 1'b1; #2;
      chk("unblock_no_req", o_dc_req, 0);
      step(); i_ag_req = 1'b1; #2;
      chk("unblock_gnt", o_ag_gnt, 1);
      step();

      // Killed load: no writeback on hit; no replay and no block on miss
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd6; i_ag_brmask = 16'h0004; #2;
      step(); i_brkill = 16'h0004; #2;
      chk("kill_hit_wb", o_wb_valid, 0);
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd6; i_ag_brmask = 16'h0004; #2;
      step(); i_brkill = 16'h0004; i_dc_hit = 1'b0; i_ag_req = 1'b1; i_ag_rd = 5'd8; #2;
      chk("kill_miss_replay", o_replay, 0);
      chk("kill_miss_gnt", o_ag_gnt, 1);
      step(); #2;
      chk("kill_next_wb_rd", o_wb_valid ? o_wb_rd : 5'h1F, 8);

      // Back-to-back hits, then a miss on the second of a burst
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k <= 3) begin i_ag_req = 1'b1; i_ag_rd = 5'(k); end
         #2;
         if (k >= 2) chk("b2b_wb_rd", o_wb_valid ? o_wb_rd : 5'h1F, 5'(k - 1));
      end
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd1; #2;
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd2; #2;
      step(); i_ag_req = 1'b1; i_ag_rd = 5'd3; i_dc_hit = 1'b0; #2;
      chk("b2b_miss_rd", o_replay ? o_replay_rd : 5'h1F, 2);
      chk("b2b_miss_no_gnt", o_ag_gnt, 0);
      step(); step();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step();
         i_rst       = ($urandom_range(0, 499) == 0);
         i_st_req    = ($urandom_range(0, 2) == 0);
         i_lr_req    = ($urandom_range(0, 3) == 0);
         i_ag_req    = ($urandom_range(0, 2) == 0);
         i_st_addr   = 4'($urandom); i_lr_addr = 4'($urandom); i_ag_addr = 4'($urandom);
         i_st_data   = $urandom;
         i_lr_rd     = 5'($urandom); i_ag_rd = 5'($urandom);
         i_lr_brmask = ($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 3)) : 16'h0;
         i_ag_brmask = ($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 3)) : 16'h0;
         i_brkill    = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(0, 3)) : 16'h0;
         i_dc_ready  = ($urandom_range(0, 3) != 0);
         i_dc_hit    = ($urandom_range(0, 3) != 0);
         #2;
         chk("wb_replay_excl", o_wb_valid & o_replay, 0);
      end

      step(); #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
